// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared widths, class encodings and constants for the bf16 packer
// Purpose: width parameters, flag bit indices, special-value constants and
//          the class decode helper used by bf16_pack and its interface.
// Ports:   none (package).
package bf16_pkg;

  localparam int NUM_WIDTH  = 16;
  localparam int EXP_WIDTH  = 8;
  localparam int SIG_WIDTH  = 7;
  localparam int FLAG_WIDTH = 4;
  localparam int MANT_WIDTH = 16;
  localparam int IEXP_WIDTH = 10;
  localparam int STAT_WIDTH = 3;
  localparam int LZ_WIDTH   = $clog2(MANT_WIDTH + 1);

  localparam int BIAS = 127;

  // Bit positions inside i_flag.
  localparam int NAN  = 3;
  localparam int ZERO = 2;
  localparam int INF  = 1;
  localparam int NORM = 0;

  localparam logic [NUM_WIDTH-1:0] QNAN    = 16'h7FFF;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Priority nan > inf > zero > norm; an all-zero flag falls through to norm,
  // so multi-hot or empty flags still resolve to exactly one class.
  function automatic cls_e decode_class(input logic [FLAG_WIDTH-1:0] flag);
    if (flag[NAN])  return CLS_NAN;
    if (flag[INF])  return CLS_INF;
    if (flag[ZERO]) return CLS_ZERO;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/bf16_pack_if.sv
// rtl/bf16_pack_if.sv - operand/result handshake bundle for bf16_pack
// Purpose: groups the input operand stream and the packed result stream.
// Ports:   none; signals i_valid/o_ready/i_flag/i_sign/i_exp/i_mant (operand in),
//          o_valid/i_ready/o_data/o_stat (result out).
//          slave modport = packer side, master modport = producer/consumer side.
interface bf16_pack_if;
  import bf16_pkg::*;

  logic                  i_valid;
  logic                  o_ready;
  logic [FLAG_WIDTH-1:0] i_flag;
  logic                  i_sign;
  logic [IEXP_WIDTH-1:0] i_exp;
  logic [MANT_WIDTH-1:0] i_mant;
  logic                  o_valid;
  logic                  i_ready;
  logic [NUM_WIDTH-1:0]  o_data;
  logic [STAT_WIDTH-1:0] o_stat;

  modport slave (
    input  i_valid, i_flag, i_sign, i_exp, i_mant, i_ready,
    output o_ready, o_valid, o_data, o_stat
  );

  modport master (
    output i_valid, i_flag, i_sign, i_exp, i_mant, i_ready,
    input  o_ready, o_valid, o_data, o_stat
  );

endinterface

// File: rtl/bf16_lzc.sv
// rtl/bf16_lzc.sv - combinational leading-zero counter
// Purpose: number of zero bits above the most significant set bit of data;
//          returns WIDTH when data is all zero.
// Ports:   data  in  WIDTH               value to scan
//          count out clog2(WIDTH+1)      leading-zero count 0..WIDTH
module bf16_lzc
  import bf16_pkg::*;
#(
  parameter int WIDTH = MANT_WIDTH
) (
  input  logic [WIDTH-1:0]               data,
  output logic [$clog2(WIDTH+1)-1:0]     count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Ascending scan: the highest set bit is visited last and wins.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/bf16_pack.sv
// rtl/bf16_pack.sv - three-stage normalise/round/pack of an unpacked float into bf16
// Purpose: stage 1 registers the operand and its leading-zero count, stage 2
//          normalises mantissa and exponent, stage 3 rounds to nearest-even,
//          handles overflow/underflow/specials and registers the bf16 result.
// Ports:   i_clk   in  rising-edge clock
//          i_rst_n in  asynchronous active-low reset
//          bus     slave modport of bf16_pack_if (operand in, result out)
module bf16_pack
  import bf16_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  bf16_pack_if.slave bus
);

  // Whole pipeline moves together; it only freezes while a result is held.
  logic en;
  assign en          = ~bus.o_valid | bus.i_ready;
  assign bus.o_ready = en;

  // ---------------- stage 1: capture operand and leading-zero count
  logic [LZ_WIDTH-1:0]   lz_in;
  logic                  s1_valid;
  cls_e                  s1_cls;
  logic                  s1_sign;
  logic [IEXP_WIDTH-1:0] s1_exp;
  logic [MANT_WIDTH-1:0] s1_mant;
  logic [LZ_WIDTH-1:0]   s1_lz;

  bf16_lzc #(.WIDTH(MANT_WIDTH)) u_lzc (
    .data  (bus.i_mant),
    .count (lz_in)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_NORM;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_lz    <= '0;
    end else if (en) begin
      s1_valid <= bus.i_valid;
      s1_cls   <= decode_class(bus.i_flag);
      s1_sign  <= bus.i_sign;
      s1_exp   <= bus.i_exp;
      s1_mant  <= bus.i_mant;
      s1_lz    <= lz_in;
    end
  end

  // ---------------- stage 2: normalise
  // Exponent widened by one bit so that i_exp - 16 can never wrap.
  logic [MANT_WIDTH-1:0] mant_n;
  logic [IEXP_WIDTH:0]   exp_n;

  assign mant_n = s1_mant << s1_lz;
  assign exp_n  = {s1_exp[IEXP_WIDTH-1], s1_exp}
                - {{(IEXP_WIDTH + 1 - LZ_WIDTH){1'b0}}, s1_lz};

  logic                  s2_valid;
  cls_e                  s2_cls;
  logic                  s2_sign;
  logic [IEXP_WIDTH:0]   s2_exp;
  logic [MANT_WIDTH-1:0] s2_mant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_cls   <= CLS_NORM;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_mant  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_cls   <= s1_cls;
      s2_sign  <= s1_sign;
      s2_exp   <= exp_n;
      s2_mant  <= mant_n;
    end
  end

  // ---------------- stage 3: round, range check, pack
  // Bit MANT_WIDTH-1 is the hidden one; the next SIG_WIDTH bits are stored,
  // the bit below is guard and everything lower folds into sticky.
  localparam int GUARD_BIT = MANT_WIDTH - 2 - SIG_WIDTH;

  logic [SIG_WIDTH-1:0]  sig_t;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [SIG_WIDTH:0]    sig_r;
  logic [IEXP_WIDTH:0]   exp_r;
  logic                  ovf;
  logic                  unf;
  logic [NUM_WIDTH-1:0]  res_data;
  logic [STAT_WIDTH-1:0] res_stat;

  assign sig_t    = s2_mant[MANT_WIDTH-2 -: SIG_WIDTH];
  assign guard    = s2_mant[GUARD_BIT];
  assign sticky   = |s2_mant[GUARD_BIT-1:0];
  assign round_up = guard & (sticky | sig_t[0]);
  assign sig_r    = {1'b0, sig_t} + {{SIG_WIDTH{1'b0}}, round_up};
  // A carry out of the fraction leaves sig_r[SIG_WIDTH-1:0] at zero and bumps the exponent.
  assign exp_r    = s2_exp + {{IEXP_WIDTH{1'b0}}, sig_r[SIG_WIDTH]};

  // exp_r is two's complement: negative or zero flushes, >= 255 saturates to inf.
  assign unf = exp_r[IEXP_WIDTH] | (exp_r == '0);
  assign ovf = ~exp_r[IEXP_WIDTH]
             & (exp_r[IEXP_WIDTH-1:0] >= {{(IEXP_WIDTH - EXP_WIDTH){1'b0}}, EXP_MAX});

  always_comb begin
    res_data = '0;
    res_stat = '0;
    case (s2_cls)
      CLS_NAN:  res_data = QNAN;
      CLS_INF:  res_data = {s2_sign, EXP_MAX, {SIG_WIDTH{1'b0}}};
      CLS_ZERO: res_data = {s2_sign, {(NUM_WIDTH-1){1'b0}}};
      default: begin
        if (s2_mant == '0) begin
          res_data = {s2_sign, {(NUM_WIDTH-1){1'b0}}};
        end else if (ovf) begin
          res_data = {s2_sign, EXP_MAX, {SIG_WIDTH{1'b0}}};
          res_stat = 3'b101;
        end else if (unf) begin
          res_data = {s2_sign, {(NUM_WIDTH-1){1'b0}}};
          res_stat = 3'b011;
        end else begin
          res_data = {s2_sign, exp_r[EXP_WIDTH-1:0], sig_r[SIG_WIDTH-1:0]};
          res_stat = {2'b00, guard | sticky};
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_stat  <= '0;
    end else if (en) begin
      bus.o_valid <= s2_valid;
      bus.o_data  <= res_data;
      bus.o_stat  <= res_stat;
    end
  end

endmodule

// File: tb/tb_bf16_pack.sv
// tb/tb_bf16_pack.sv - self-checking bench for bf16_pack
module tb_bf16_pack;
  import bf16_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bf16_pack_if bus();

  bf16_pack dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [18:0] exp_q[$];

  typedef struct {
    logic [3:0]  f;
    logic        s;
    logic [9:0]  e;
    logic [15:0] m;
    logic [15:0] d;
    logic [2:0]  st;
  } dvec_t;

  // Reference: {stat[2:0], data[15:0]} from the value-level definition.
  function automatic logic [18:0] model(input logic [3:0] f, input logic s,
                                        input logic [9:0] ex, input logic [15:0] m);
    int e, mm, frac, sig, rem;
    if (f[3]) return {3'b000, 16'h7FFF};
    if (f[1]) return {3'b000, s, 8'hFF, 7'h00};
    if (f[2]) return {3'b000, s, 15'h0};
    if (m == 0) return {3'b000, s, 15'h0};
    e  = $signed(ex);
    mm = m;
    while (mm < 32768) begin
      mm = mm * 2;
      e  = e - 1;
    end
    frac = mm - 32768;
    sig  = frac / 256;
    rem  = frac % 256;
    if (rem > 128 || (rem == 128 && (sig % 2) == 1)) sig = sig + 1;
    if (sig == 128) begin
      sig = 0;
      e   = e + 1;
    end
    if (e >= 255) return {3'b101, s, 8'hFF, 7'h00};
    if (e <= 0)   return {3'b011, s, 15'h0};
    return {2'b00, rem != 0, s, 8'(e), 7'(sig)};
  endfunction

  task automatic rand_operand();
    logic [15:0] m;
    case ($urandom_range(0, 9))
      0: bus.i_flag = 4'b1000;
      1: bus.i_flag = 4'b0010;
      2: bus.i_flag = 4'b0100;
      3: bus.i_flag = 4'b0000;
      4: bus.i_flag = 4'($urandom);
      default: bus.i_flag = 4'b0001;
    endcase
    bus.i_sign = 1'($urandom);
    case ($urandom_range(0, 3))
      0: bus.i_exp = 10'($urandom);
      1: bus.i_exp = 10'($urandom_range(0, 20));
      2: bus.i_exp = 10'($urandom_range(245, 270));
      default: bus.i_exp = 10'($urandom_range(100, 160));
    endcase
    m = 16'($urandom);
    bus.i_mant = m >> $urandom_range(0, 16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_flag = 4'b0001;
    bus.i_sign = 1'b0;
    bus.i_exp = '0;
    bus.i_mant = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid);
    end
    vectors++;
    if (bus.o_data !== 16'h0 || bus.o_stat !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%b expected 0000/000", bus.o_data, bus.o_stat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_o_ready: got %b expected 1", bus.o_ready);
    end
    bus.i_ready = 1'b1;
  endtask

  task automatic test_directed();
    dvec_t tbl[12];
    tbl[0]  = '{4'b0001, 1'b0, 10'd127, 16'h8000, 16'h3F80, 3'b000};
    tbl[1]  = '{4'b0001, 1'b0, 10'd142, 16'h0001, 16'h3F80, 3'b000};
    tbl[2]  = '{4'b0001, 1'b0, 10'd127, 16'h8180, 16'h3F82, 3'b001};
    tbl[3]  = '{4'b0001, 1'b0, 10'd127, 16'h8080, 16'h3F80, 3'b001};
    tbl[4]  = '{4'b0001, 1'b0, 10'd254, 16'hFFFF, 16'h7F80, 3'b101};
    tbl[5]  = '{4'b0001, 1'b0, 10'd5,   16'h0004, 16'h0000, 3'b011};
    tbl[6]  = '{4'b1000, 1'b0, 10'd3,   16'h1234, 16'h7FFF, 3'b000};
    tbl[7]  = '{4'b0010, 1'b1, 10'd3,   16'h1234, 16'hFF80, 3'b000};
    tbl[8]  = '{4'b0100, 1'b1, 10'd3,   16'h1234, 16'h8000, 3'b000};
    tbl[9]  = '{4'b1010, 1'b1, 10'd3,   16'h1234, 16'h7FFF, 3'b000};
    tbl[10] = '{4'b0000, 1'b1, 10'd127, 16'h8000, 16'hBF80, 3'b000};
    tbl[11] = '{4'b0001, 1'b1, 10'd200, 16'h0000, 16'h8000, 3'b000};
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      bus.i_valid = 1'b1;
      bus.i_flag = tbl[i].f;
      bus.i_sign = tbl[i].s;
      bus.i_exp = tbl[i].e;
      bus.i_mant = tbl[i].m;
      bus.i_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.o_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL dir%0d_accept: o_ready got %b expected 1", i, bus.o_ready);
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== (c == 3)) begin
          miscompares++;
          $display("FAIL dir%0d_latency c%0d: o_valid got %b expected %b", i, c, bus.o_valid, c == 3);
        end
      end
      vectors++;
      if (bus.o_data !== tbl[i].d || bus.o_stat !== tbl[i].st) begin
        miscompares++;
        $display("FAIL dir%0d_result: got %h/%b expected %h/%b", i, bus.o_data, bus.o_stat, tbl[i].d, tbl[i].st);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_stream();
    logic hold;
    logic [15:0] held_d;
    logic [2:0] held_s;
    logic [18:0] e;
    int guard_cnt;
    hold = 1'b0;
    held_d = '0;
    held_s = '0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      bus.i_valid = ($urandom_range(0, 9) < 7);
      bus.i_ready = ($urandom_range(0, 9) < 7);
      rand_operand();
      @(negedge clk);
      if (hold) begin
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== held_d || bus.o_stat !== held_s) begin
          miscompares++;
          $display("FAIL rnd_hold: got %b %h/%b expected 1 %h/%b", bus.o_valid, bus.o_data, bus.o_stat, held_d, held_s);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_extra: got %h with nothing expected", bus.o_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_stat, bus.o_data} !== e) begin
            miscompares++;
            $display("FAIL rnd_result: got %b/%h expected %b/%h", bus.o_stat, bus.o_data, e[18:16], e[15:0]);
          end
        end
      end
      if (bus.i_valid && bus.o_ready)
        exp_q.push_back(model(bus.i_flag, bus.i_sign, bus.i_exp, bus.i_mant));
      hold = bus.o_valid && !bus.i_ready;
      held_d = bus.o_data;
      held_s = bus.o_stat;
    end
    guard_cnt = 0;
    while (exp_q.size() != 0 && guard_cnt < 20) begin
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(negedge clk);
      if (bus.o_valid) begin
        vectors++;
        e = exp_q.pop_front();
        if ({bus.o_stat, bus.o_data} !== e) begin
          miscompares++;
          $display("FAIL rnd_drain: got %b/%h expected %b/%h", bus.o_stat, bus.o_data, e[18:16], e[15:0]);
        end
      end
      guard_cnt++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_lost: %0d results outstanding expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [3:0] fl[5];
    logic sg[5];
    logic [9:0] ex[5];
    logic [15:0] mn[5];
    logic [18:0] e;
    logic hold;
    logic [15:0] held_d;
    int sent, got, stalls;
    for (int i = 0; i < 5; i++) begin
      fl[i] = 4'b0001;
      sg[i] = 1'($urandom);
      ex[i] = 10'($urandom_range(110, 140));
      mn[i] = 16'($urandom) | 16'h0100;
    end
    sent = 0;
    got = 0;
    stalls = 0;
    hold = 1'b0;
    held_d = '0;
    exp_q.delete();
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(posedge clk);
      #1;
      bus.i_valid = (sent < 5);
      if (sent < 5) begin
        bus.i_flag = fl[sent];
        bus.i_sign = sg[sent];
        bus.i_exp = ex[sent];
        bus.i_mant = mn[sent];
      end
      bus.i_ready = !(c >= 4 && c < 8);
      @(negedge clk);
      if (bus.o_valid && !bus.i_ready) begin
        stalls++;
        vectors++;
        if (bus.o_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_o_ready: got %b expected 0 during stall", bus.o_ready);
        end
      end
      if (hold) begin
        vectors++;
        if (bus.o_data !== held_d) begin
          miscompares++;
          $display("FAIL bp_stable: got %h expected %h", bus.o_data, held_d);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        got++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 19'h7FFFF;
        if ({bus.o_stat, bus.o_data} !== e) begin
          miscompares++;
          $display("FAIL bp_result%0d: got %b/%h expected %b/%h", got, bus.o_stat, bus.o_data, e[18:16], e[15:0]);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(model(fl[sent], sg[sent], ex[sent], mn[sent]));
        sent++;
      end
      hold = bus.o_valid && !bus.i_ready;
      held_d = bus.o_data;
    end
    vectors++;
    if (got != 5 || stalls != 4) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results %0d stalls expected 5 results 4 stalls", got, stalls);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_duplicate: o_valid got %b expected 0", bus.o_valid);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_inflight();
    logic [18:0] e;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.i_valid = 1'b1;
      bus.i_flag = 4'b0001;
      bus.i_sign = 1'b0;
      bus.i_exp = 10'd127;
      bus.i_mant = 16'h8000;
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 16'h0 || bus.o_stat !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_flight: got %b %h/%b expected 0 0000/000", bus.o_valid, bus.o_data, bus.o_stat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_ghost: o_valid got %b expected 0", bus.o_valid);
      end
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    rand_operand();
    bus.i_flag = 4'b0001;
    bus.i_mant = bus.i_mant | 16'h0001;
    e = model(bus.i_flag, bus.i_sign, bus.i_exp, bus.i_mant);
    @(negedge clk);
    vectors++;
    if (bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_accept: o_ready got %b expected 1", bus.o_ready);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.o_valid !== (c == 3)) begin
        miscompares++;
        $display("FAIL rst_latency c%0d: o_valid got %b expected %b", c, bus.o_valid, c == 3);
      end
    end
    vectors++;
    if ({bus.o_stat, bus.o_data} !== e) begin
      miscompares++;
      $display("FAIL rst_result: got %b/%h expected %b/%h", bus.o_stat, bus.o_data, e[18:16], e[15:0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random_stream();
    test_backpressure();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
